// File: rtl/mem_output_collector_if.sv
// mem_output_collector_if: producer-to-collector result output handshake
interface mem_output_collector_if;
    logic         output_request;
    logic         output_permit;
    logic [511:0] output_data;
    logic         output_valid;
    logic         output_finish;
    modport master (
        output output_request, output_data, output_valid, output_finish,
        input  output_permit
    );
    modport slave (
        input  output_request, output_data, output_valid, output_finish,
        output output_permit
    );
endinterface

// File: rtl/mem_output_collector.sv
// mem_output_collector: captures framed result lines, buffers them and streams them to host writes
module mem_output_collector #(
    parameter int FIFO_DEPTH     = 32,
    parameter int SKID           = 8,
    parameter int ADDR_W         = 32,
    parameter int READ_NUM_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    input  logic [ADDR_W-1:0]         base_addr,
    mem_output_collector_if.slave     prod,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [511:0]              wr_data,
    output logic [31:0]               lines_written,
    output logic [READ_NUM_WIDTH:0]   groups_seen,
    output logic                      done,
    output logic                      proto_err,
    output logic                      overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_GAP} state_t;

    logic [511:0]            r_mem [FIFO_DEPTH];
    logic [AW:0]             r_wptr, r_rptr;
    logic                    r_out_valid;
    logic [511:0]            r_out_data;
    logic [31:0]             r_lines;
    logic [READ_NUM_WIDTH:0] r_groups;
    logic [7:0]              r_rem;
    logic                    r_proto, r_overflow, r_finish, r_done, r_permit;
    state_t                  r_state, w_next, w_hdr_next;

    logic [AW:0]             w_count, w_free;
    logic                    w_empty, w_full, w_push, w_pop, w_write, w_drop, w_gap;
    logic                    w_hdr, w_frame_err, w_num_err, w_fin_set, w_fin_err;
    logic [7:0]              w_hdr_rem;
    logic [READ_NUM_WIDTH:0] w_groups_nxt;

    assign w_count      = r_wptr - r_rptr;
    assign w_free       = (AW+1)'(FIFO_DEPTH) - w_count;
    assign w_empty      = w_count == '0;
    assign w_full       = w_count == (AW+1)'(FIFO_DEPTH);
    assign w_push       = prod.output_valid && !stall;
    assign w_gap        = !prod.output_valid && !stall;
    assign w_pop        = !w_empty && (!r_out_valid || wr_ready);
    assign w_write      = w_push && (!w_full || w_pop);
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_hdr_rem    = (8'(prod.output_data[70:64]) + 8'd1) >> 1;
    assign w_hdr_next   = (w_hdr_rem == 8'd0) ? S_IDLE : S_PAYLOAD;
    assign w_groups_nxt = r_groups + {{READ_NUM_WIDTH{1'b0}}, w_hdr};
    assign w_fin_set    = prod.output_finish && !stall && !r_finish;
    assign w_fin_err    = w_fin_set && (w_groups_nxt != batch_size);

    assign prod.output_permit = r_permit;
    assign wr_valid      = r_out_valid;
    assign wr_data       = r_out_data;
    assign wr_addr       = base_addr + ADDR_W'(r_lines);
    assign lines_written = r_lines;
    assign groups_seen   = r_groups;
    assign done          = r_done;
    assign proto_err     = r_proto;
    assign overflow_err  = r_overflow;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wptr[AW-1:0]] <= prod.output_data;
    end

    // FIFO pointers: a full FIFO still accepts a push when the head moves out the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_write) r_wptr <= r_wptr + 1'b1;
            if (w_pop)   r_rptr <= r_rptr + 1'b1;
        end
    end

    // Registered write stage: reloads from the FIFO head when empty or accepted, holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_lines     <= '0;
        end else begin
            if (!r_out_valid || wr_ready) r_out_valid <= !w_empty;
            if (w_pop) r_out_data <= r_mem[r_rptr[AW-1:0]];
            if (r_out_valid && wr_ready) r_lines <= r_lines + 32'd1;
        end
    end

    // Framing state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Framing next state: header -> payload lines -> one idle cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = w_push ? w_hdr_next : S_IDLE;
            S_PAYLOAD: w_next = w_push ? (r_rem == 8'd1 ? S_GAP : S_PAYLOAD) : (w_gap ? S_IDLE : S_PAYLOAD);
            S_GAP:     w_next = w_push ? w_hdr_next : (w_gap ? S_IDLE : S_GAP);
            default:   w_next = S_IDLE;
        endcase
    end

    // Framing outputs: header detection and framing violations
    always_comb begin
        w_hdr       = w_push && (r_state != S_PAYLOAD);
        w_frame_err = (r_state == S_GAP && w_push) || (r_state == S_PAYLOAD && w_gap);
        w_num_err   = w_hdr && (prod.output_data[READ_NUM_WIDTH:0] != r_groups);
    end

    // Group bookkeeping, sticky errors, permit and completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_groups   <= '0;
            r_proto    <= 1'b0;
            r_overflow <= 1'b0;
            r_finish   <= 1'b0;
            r_done     <= 1'b0;
            r_permit   <= 1'b0;
        end else begin
            if (w_hdr) r_rem <= w_hdr_rem;
            else if (r_state == S_PAYLOAD && w_push) r_rem <= r_rem - 8'd1;
            r_groups   <= w_groups_nxt;
            r_proto    <= r_proto | w_frame_err | w_num_err | w_fin_err;
            r_overflow <= r_overflow | w_drop;
            r_finish   <= r_finish | w_fin_set;
            r_done     <= r_done | (r_finish && w_empty && !r_out_valid);
            r_permit   <= prod.output_request && (w_free >= (AW+1)'(SKID)) && !r_finish;
        end
    end
endmodule

// File: doc/mem_output_collector.md
Name: mem_output_collector

Overview:
Consumer end of the mem-queue result output handshake (output_request / output_permit / output_data / output_valid / output_finish).
- Grants output_permit to the mem/curr RAM block only while it has buffer room.
- Captures the 512-bit result lines and checks them against the group framing: one header line, then ceil(mem_size/2) payload lines per read.
- Buffers the lines in a FIFO and streams them to the host write channel at consecutive cacheline addresses.
- Signals batch completion.

Parameters:
FIFO_DEPTH, 32, capture FIFO entries (512 b each), power of two
SKID, 8, minimum free entries required to hold permit (covers the 6-cycle permit-to-valid pipeline plus margin)
ADDR_W, 32, host cacheline address width
READ_NUM_WIDTH, 9, read index width; header read field is READ_NUM_WIDTH+1 bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  global pipeline stall; the producer freezes while high
batch_size  in  READ_NUM_WIDTH+1  number of read groups expected
base_addr  in  ADDR_W  first host cacheline address
output_request  in  1  producer has results ready
output_permit  out  1  producer may advance its output pointer
output_data  in  512  result line
output_valid  in  1  output_data valid (ignored while stall)
output_finish  in  1  producer has sent all groups (level)
wr_valid  out  1  host write request valid
wr_ready  in  1  host accepts write
wr_addr  out  ADDR_W  cacheline address
wr_data  out  512  line data
lines_written  out  32  accepted host writes
groups_seen  out  READ_NUM_WIDTH+1  headers captured
done  out  1  batch complete (level)
proto_err  out  1  sticky framing error
overflow_err  out  1  sticky push-while-full

Behaviour:
- Reset (synchronous, active-high): all outputs are 0 on the following edge; FIFO is emptied; counters, state and sticky flags are cleared. Reset mid-batch discards buffered lines; no wr_valid is issued after the reset edge.
- Permit: registered. output_permit <= output_request && (free_entries >= SKID) && !finish_seen. Evaluated every cycle, including during stall.
- Capture: push = output_valid && !stall. During stall the producer holds its outputs, so nothing is captured.
- If push occurs while the FIFO is full, the line is dropped and overflow_err is set.
- Framing FSM (advances only on push):
  - IDLE, on push: the line is a header. Latch mem_size = data[70:64]. Set remaining = (mem_size + 1) >> 1 (8-bit arithmetic). groups_seen++.
    - remaining == 0 -> stay in IDLE.
    - otherwise -> PAYLOAD.
  - PAYLOAD, on push: remaining--. remaining reaching 0 -> GAP.
  - PAYLOAD, output_valid low for a cycle (not stalled) while remaining != 0 -> proto_err, go to IDLE.
  - GAP: waits for one non-stalled cycle with output_valid low, then -> IDLE. A push while in GAP -> proto_err; the line is treated as a header.
- Header fields: read num = data[9:0], ret = data[159:128]. A header whose read num differs from groups_seen (value before increment) sets proto_err. Data is still forwarded.
- All pushed lines, header and payload alike, are forwarded unmodified.
- Host write:
  - wr_valid = FIFO not empty, driven from a registered output stage. wr_data = FIFO head.
  - wr_addr = base_addr + lines_written, wrapping modulo 2^ADDR_W.
  - On wr_valid && wr_ready: pop, lines_written++.
  - wr_data and wr_addr hold stable while wr_valid && !wr_ready.
  - The write channel is not affected by stall.
- Simultaneous push and pop on a full FIFO is legal: no overflow.
- finish_seen: set when output_finish && !stall. Once set, it drops permit.
- done: asserts the cycle after all of finish_seen, FIFO empty and !wr_valid hold. Stays high until reset.
- When finish_seen sets, groups_seen != batch_size -> proto_err.
- Latency: a pushed line into an empty FIFO reaches wr_valid 2 cycles later.

Test Plan:
1. batch_size=2; groups with mem_size 3 and 2; wr_ready=1 -> 2+1+2 = 5 lines written at base_addr+0..4; groups_seen=2; done=1; no errors.
2. mem_size=0 group followed by mem_size=1 group -> 1 line, then header+1 line; 3 writes; proto_err=0.
3. wr_ready=0 for 200 cycles with request high -> permit drops when free < 8; no overflow_err; all lines drain in order once wr_ready=1.
4. stall held 10 cycles mid-payload with output_valid high -> no duplicate capture; line count still equals 1 + ceil(mem_size/2).
5. Header with read num 5 when groups_seen=0, or valid dropping with 1 payload line remaining -> proto_err=1 and held.
6. reset asserted mid-PAYLOAD with 6 lines queued -> next cycle wr_valid=0, permit=0, counters 0; a new batch then completes normally.
